// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding and architectural register constants.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    MEMWAIT = 3'd2,
    FLUSH   = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // FLUSH_CYCLES is limited to 1..7, so the flush counter never needs more bits.
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Status/control bundle between the pipeline datapath and pipe_ctrl.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(parameter int CNT_W = 16);

  logic             start;
  logic             ir_already;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1en;
  logic             id_rs2en;
  logic             ex_load;
  logic [4:0]       ex_rd;
  logic             branch_taken;
  logic             mem_busy;
  logic             sys_halt;
  logic             run_en;
  logic             flush;
  logic             ex_bubble;
  logic             pc_hold;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  start, ir_already, id_rs1, id_rs2, id_rs1en, id_rs2en,
           ex_load, ex_rd, branch_taken, mem_busy, sys_halt,
    output run_en, flush, ex_bubble, pc_hold, halted, stall_cnt
  );

  modport slave (
    output start, ir_already, id_rs1, id_rs2, id_rs1en, id_rs2en,
           ex_load, ex_rd, branch_taken, mem_busy, sys_halt,
    input  run_en, flush, ex_bubble, pc_hold, halted, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags when the decode instruction reads
// the destination of a LOAD currently in EX (x0 never creates a hazard).
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1en,
  input  logic       id_rs2en,
  output logic       hazard
);

  logic [1:0][4:0] src_idx;
  logic [1:0]      src_en;
  logic [1:0]      src_hit;

  assign src_idx = {id_rs2, id_rs1};
  assign src_en  = {id_rs2en, id_rs1en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_en[gi] && (src_idx[gi] == ex_rd);
  end

  assign hazard = ex_load && (ex_rd != REG_X0) && (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: decode advance/flush, EX bubble, PC hold,
// halt tracking and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.master bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic                   MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic stall_cyc;
  logic run_en, flush, ex_bubble, pc_hold, halted;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .ex_load  (bus.ex_load),
    .ex_rd    (bus.ex_rd),
    .id_rs1   (bus.id_rs1),
    .id_rs2   (bus.id_rs2),
    .id_rs1en (bus.id_rs1en),
    .id_rs2en (bus.id_rs2en),
    .hazard   (hazard)
  );

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    run_en    = 1'b0;
    flush     = 1'b0;
    ex_bubble = 1'b0;
    pc_hold   = 1'b1;
    halted    = 1'b0;
    stall_cyc = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end

      HALT: begin
        halted    = 1'b1;
        ex_bubble = 1'b1;
        if (bus.start) state_d = RUN;
      end

      FLUSH: begin
        run_en    = 1'b1;
        flush     = 1'b1;
        ex_bubble = 1'b1;
        pc_hold   = 1'b0;
        stall_cyc = 1'b1;
        if (bus.branch_taken) begin
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q <= FLUSH_CNT_W'(1)) begin
          fcnt_d  = '0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
        end
      end

      // The cycle mem_busy drops in MEMWAIT is handled exactly like a RUN cycle.
      RUN, MEMWAIT: begin
        if (state_q == MEMWAIT && bus.mem_busy) begin
          stall_cyc = 1'b1;
        end else if (bus.branch_taken) begin
          run_en    = 1'b1;
          flush     = 1'b1;
          ex_bubble = 1'b1;
          pc_hold   = 1'b0;
          stall_cyc = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else if (bus.sys_halt) begin
          ex_bubble = 1'b1;
          state_d   = HALT;
        end else if (bus.mem_busy) begin
          stall_cyc = 1'b1;
          state_d   = MEMWAIT;
        end else if (hazard) begin
          ex_bubble = 1'b1;
          stall_cyc = 1'b1;
          state_d   = RUN;
        end else begin
          run_en  = bus.ir_already;
          pc_hold = ~bus.ir_already;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_cyc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.run_en    = run_en;
  assign bus.flush     = flush;
  assign bus.ex_bubble = ex_bubble;
  assign bus.pc_hold   = pc_hold;
  assign bus.halted    = halted;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the fetch/decode/execute front end.
- Generates the decode-stage advance enable (run_en) and flush, the EX-stage bubble insert and the PC hold.
- Resolves load-use hazards, multi-cycle memory waits, taken-branch/jump redirects and SYSTEM halts.
- Sits beside the decode register stage and drives its run_en/flush inputs directly.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (legal range 1..7)
- CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE or HALT and begins execution
- ir_already  in  1  fetch has a valid instruction presented to decode
- id_rs1  in  5  rs1 index of instruction in decode output registers
- id_rs2  in  5  rs2 index of instruction in decode output registers
- id_rs1en  in  1  rs1 is read by that instruction
- id_rs2en  in  1  rs2 is read by that instruction
- ex_load  in  1  instruction in EX is a LOAD
- ex_rd  in  5  destination of instruction in EX
- branch_taken  in  1  EX resolved a taken BRANCH/JAL/JALR; PC redirected this cycle
- mem_busy  in  1  LSU multi-cycle access in progress
- sys_halt  in  1  SYSTEM (ECALL/EBREAK) instruction retiring from EX
- run_en  out  1  decode registers advance this cycle
- flush  out  1  decode registers load zeros (valid only with run_en=1)
- ex_bubble  out  1  EX stage captures a NOP instead of decode output
- pc_hold  out  1  fetch holds PC and ir
- halted  out  1  core in HALT
- stall_cnt  out  CNT_W  saturating count of non-advancing or flushed cycles

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. The clock port is named clk and the reset port is named reset.
- Reset values: state=IDLE, flush counter=0, stall_cnt=0.
- Outputs at reset: run_en=0, flush=0, ex_bubble=0, pc_hold=1, halted=0.
- States: IDLE, RUN, MEMWAIT, FLUSH, HALT. State is registered; outputs are combinational from state plus current inputs, with zero-cycle latency.
- IDLE: run_en=0, pc_hold=1. start goes to RUN next cycle; all other inputs are ignored.
- RUN priority, highest first: branch_taken > sys_halt > mem_busy > load-use hazard > normal.
  - branch_taken: run_en=1, flush=1, ex_bubble=1, pc_hold=0. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - sys_halt: run_en=0, ex_bubble=1, pc_hold=1; go to HALT.
  - mem_busy: run_en=0, pc_hold=1, ex_bubble=0 (EX holds); go to MEMWAIT.
  - Load-use hazard: ex_load && ex_rd!=0 && ((id_rs1en && id_rs1==ex_rd) || (id_rs2en && id_rs2==ex_rd)). Output run_en=0, pc_hold=1, ex_bubble=1 for exactly this cycle and remain in RUN; the bubble clears ex_load the following cycle.
  - Normal: run_en=ir_already, pc_hold=~ir_already, all other outputs 0.
- MEMWAIT: run_en=0, pc_hold=1 while mem_busy=1.
  - mem_busy falling returns to RUN; RUN rules apply from that cycle.
  - branch_taken during MEMWAIT is ignored; the LSU guarantees this cannot occur.
- FLUSH: run_en=1, flush=1, pc_hold=0, ex_bubble=1. Counter decrements each cycle; at 1 go to RUN.
  - A new branch_taken in FLUSH reloads counter=FLUSH_CYCLES-1.
  - sys_halt and mem_busy are ignored in FLUSH (only bubbles are in EX).
- HALT: halted=1, run_en=0, pc_hold=1, ex_bubble=1. start goes to RUN.
- start asserted in RUN, MEMWAIT or FLUSH is ignored.
- stall_cnt increments by 1 in every cycle where state is MEMWAIT or FLUSH, or a RUN cycle with hazard, branch_taken or mem_busy. It saturates at all-ones and clears only on reset.
- Reset mid-operation (any state, any counter value) returns immediately to IDLE values.

Decomposition:
- Shared package holds the state encoding constants: IDLE=3'd0, RUN=3'd1, MEMWAIT=3'd2, FLUSH=3'd3, HALT=3'd4.
- The package also holds the x0 register index constant 5'd0.
- One natural sub-module: hazard_detect, a purely combinational load-use comparator producing a single hazard bit.
- The FSM, flush counter and performance counter stay in pipe_ctrl.

Test Plan:
- Reset then start pulse, ir_already=1 steady -> cycle after start: run_en=1, pc_hold=0, flush=0; stall_cnt=0.
- ex_load=1, ex_rd=5, id_rs2en=1, id_rs2=5 for one cycle -> run_en=0, ex_bubble=1, pc_hold=1 that cycle only; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- branch_taken pulse with FLUSH_CYCLES=2 -> flush=1 for 2 consecutive cycles, then RUN; second branch_taken in the FLUSH cycle -> flush extended to 3 total cycles.
- mem_busy high 4 cycles -> run_en=0, ex_bubble=0 for 4 cycles, RUN on the 5th cycle; stall_cnt +=4.
- sys_halt and mem_busy asserted together -> HALT (priority), halted=1. Ignore mem_busy. start -> RUN, halted=0.
- Force stall_cnt to 0xFFFE via 2 further stalls -> reads 0xFFFF and holds. Async reset asserted mid-FLUSH -> all outputs return to reset values before the next clk edge.
